// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared widths, opcode constants and instruction field positions.
// Revision : 1.0
// ============================================================================
package cpu_pkg;

    localparam int ADDR_W  = 10;
    localparam int INSTR_W = 18;
    localparam int OP_W    = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'h0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h1;
    localparam logic [OP_W-1:0] OP_AND  = 4'h2;
    localparam logic [OP_W-1:0] OP_OR   = 4'h3;
    localparam logic [OP_W-1:0] OP_LDI  = 4'h4;
    localparam logic [OP_W-1:0] OP_LD   = 4'h5;
    localparam logic [OP_W-1:0] OP_ST   = 4'h6;
    localparam logic [OP_W-1:0] OP_JMP  = 4'h7;
    localparam logic [OP_W-1:0] OP_BEQ  = 4'h8;
    localparam logic [OP_W-1:0] OP_HALT = 4'hF;

    localparam int OPC_HI  = 17;
    localparam int OPC_LO  = 14;
    localparam int DST_HI  = 13;
    localparam int DST_LO  = 10;
    localparam int SRC1_HI = 9;
    localparam int SRC1_LO = 6;
    localparam int IMM_HI  = 5;
    localparam int IMM_LO  = 0;

    function automatic logic [OP_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[OPC_HI:OPC_LO];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Brief    : Two-entry synchronous FIFO; entry 0 is always the head.
// Revision : 1.0
// ============================================================================
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int W = ADDR_W + INSTR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] r_ent0;
    logic [W-1:0] r_ent1;
    logic [1:0]   r_count;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b11: begin
                    // count is unchanged; the new entry slots in behind whatever remains
                    if (r_count == 2'd2) begin
                        r_ent0 <= r_ent1;
                        r_ent1 <= wdata;
                    end else begin
                        r_ent0 <= wdata;
                    end
                end
                2'b10: begin
                    if (r_count == 2'd0) r_ent0 <= wdata;
                    else                 r_ent1 <= wdata;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_ent0  <= r_ent1;
                    r_count <= r_count - 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign head  = r_ent0;
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Fetch stage: PC, imem drive, 2-entry output queue, halt FSM.
// Revision : 1.0
// ============================================================================
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                 ADDR_W   = cpu_pkg::ADDR_W,
    parameter int                 INSTR_W  = cpu_pkg::INSTR_W,
    parameter int                 OP_W     = cpu_pkg::OP_W,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter logic [OP_W-1:0]    HALT_OP  = cpu_pkg::OP_HALT
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [OP_W-1:0]    out_opcode,
    output logic               halted,
    output logic [ADDR_W-1:0]  fetch_pc
);

    localparam int         c_QW          = ADDR_W + INSTR_W;
    localparam logic [0:0] c_ST_FETCH    = 1'b0;
    localparam logic [0:0] c_ST_HALTED   = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [ADDR_W-1:0]  r_fetch_pc;
    logic [c_QW-1:0]    w_head;
    logic [1:0]         w_count;
    logic               w_valid;
    logic               w_pop;
    logic               w_push;
    logic               w_push_halt;

    assign w_valid = (w_count != 2'd0);
    // a redirect discards the head, so it must not count as consumed
    assign w_pop   = w_valid & out_ready & ~redirect_valid;
    assign w_push  = (r_state == c_ST_FETCH) & ~redirect_valid
                   & ((w_count != 2'd2) | w_pop);
    assign w_push_halt = w_push & (imem_data[INSTR_W-1 -: OP_W] == HALT_OP);

    fetch_queue #(
        .W (c_QW)
    ) u_queue (
        .clk   (clk),
        .rst   (~reset),
        .push  (w_push),
        .pop   (w_pop),
        .flush (redirect_valid),
        .wdata ({r_fetch_pc, imem_data}),
        .head  (w_head),
        .count (w_count)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= c_ST_FETCH;
            r_fetch_pc <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            if (redirect_valid)  r_fetch_pc <= redirect_target;
            else if (w_push)     r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (redirect_valid)   w_state_nxt = c_ST_FETCH;
        else if (w_push_halt) w_state_nxt = c_ST_HALTED;
    end

    assign imem_addr  = r_fetch_pc;
    assign fetch_pc   = r_fetch_pc;
    assign halted     = (r_state == c_ST_HALTED);
    assign out_valid  = w_valid;
    assign out_pc     = w_valid ? w_head[c_QW-1 -: ADDR_W]  : '0;
    assign out_instr  = w_valid ? w_head[INSTR_W-1:0]       : '0;
    assign out_opcode = out_instr[INSTR_W-1 -: OP_W];

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Self-checking bench for fetch_unit against a queue-level model.
// Revision : 1.0
// ============================================================================
module tb_fetch_unit;

    localparam int c_AW = 10;
    localparam int c_IW = 18;

    logic            clk = 1'b0;
    logic            reset;
    logic [c_AW-1:0] imem_addr;
    logic [c_IW-1:0] imem_data;
    logic            redirect_valid;
    logic [c_AW-1:0] redirect_target;
    logic            out_valid;
    logic            out_ready;
    logic [c_IW-1:0] out_instr;
    logic [c_AW-1:0] out_pc;
    logic [3:0]      out_opcode;
    logic            halted;
    logic [c_AW-1:0] fetch_pc;

    logic [c_IW-1:0] mem [1024];

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    typedef struct { int pc; int instr; } entry_t;
    entry_t m_q[$];
    int     m_pc;
    bit     m_halt;
    int     accepted[$];

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_pc          (out_pc),
        .out_opcode      (out_opcode),
        .halted          (halted),
        .fetch_pc        (fetch_pc)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a plain bounded queue of {pc, instr} with a halt flag
    always @(posedge clk) begin
        bit do_pop;
        bit do_push;
        if (!reset) begin
            m_q.delete();
            m_pc   = 0;
            m_halt = 1'b0;
        end else if (redirect_valid) begin
            m_q.delete();
            m_pc   = int'(redirect_target);
            m_halt = 1'b0;
        end else begin
            do_pop  = (m_q.size() > 0) && out_ready;
            do_push = !m_halt && ((m_q.size() < 2) || do_pop);
            if (do_pop) begin
                accepted.push_back(m_q[0].pc);
                void'(m_q.pop_front());
            end
            if (do_push) begin
                m_q.push_back('{pc: m_pc, instr: int'(mem[m_pc])});
                if (mem[m_pc][17:14] == 4'hF) m_halt = 1'b1;
                m_pc = (m_pc + 1) % 1024;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("out_valid", int'(out_valid), (m_q.size() > 0) ? 1 : 0);
            if (m_q.size() > 0) begin
                chk("out_pc",     int'(out_pc),     m_q[0].pc);
                chk("out_instr",  int'(out_instr),  m_q[0].instr);
                chk("out_opcode", int'(out_opcode), (m_q[0].instr >> 14) & 15);
            end else begin
                chk("out_pc_empty",    int'(out_pc),    0);
                chk("out_instr_empty", int'(out_instr), 0);
            end
            chk("halted",    int'(halted),    m_halt ? 1 : 0);
            chk("fetch_pc",  int'(fetch_pc),  m_pc);
            chk("imem_addr", int'(imem_addr), m_pc);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = c_IW'(i);
        reset           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        out_ready       = 1'b0;

        // reset held for two edges
        tick();
        check_en = 1'b1;
        tick();
        chk("rst_valid",    int'(out_valid), 0);
        chk("rst_halted",   int'(halted),    0);
        chk("rst_fetch_pc", int'(fetch_pc),  0);

        // run with ready high: 0,1,2,3 on consecutive cycles
        reset = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("run_pc",    int'(out_pc),    i);
            chk("run_instr", int'(out_instr), i);
        end

        // backpressure from reset release
        reset = 1'b0; tick();
        reset = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("bp_fetch_pc", int'(fetch_pc), 2);
        chk("bp_out_pc",   int'(out_pc),   0);
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("bp_drain_pc", int'(out_pc), i);
        end

        // fill queue with 7,8 then redirect to 500
        out_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 10'd7;
        tick();
        redirect_valid = 1'b0;
        tick(); tick();
        chk("q78_head", int'(out_pc),   7);
        chk("q78_fpc",  int'(fetch_pc), 9);
        accepted.delete();
        redirect_valid = 1'b1; redirect_target = 10'd500; out_ready = 1'b1;
        tick();
        chk("redir_valid", int'(out_valid), 0);
        redirect_valid = 1'b0;
        tick();
        chk("redir_pc0", int'(out_pc), 500);
        tick();
        chk("redir_pc1", int'(out_pc), 501);
        begin
            int stale = 0;
            foreach (accepted[k]) if (accepted[k] == 7 || accepted[k] == 8) stale++;
            chk("redir_no_stale", stale, 0);
        end

        // wrap around the top of the address space
        redirect_valid = 1'b1; redirect_target = 10'd1022;
        tick();
        redirect_valid = 1'b0;
        tick(); chk("wrap0", int'(out_pc), 1022);
        tick(); chk("wrap1", int'(out_pc), 1023);
        tick(); chk("wrap2", int'(out_pc), 0);
        tick(); chk("wrap3", int'(out_pc), 1);

        // halt at pc 3
        mem[3] = {4'hF, 14'd3};
        reset = 1'b0; tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("halt_seq_pc", int'(out_pc), i);
        end
        chk("halt_flag",   int'(halted),     1);
        chk("halt_opcode", int'(out_opcode), 15);
        chk("halt_fpc",    int'(fetch_pc),   4);
        tick();
        chk("halt_drained", int'(out_valid), 0);
        tick();
        chk("halt_frozen",  int'(fetch_pc),  4);
        redirect_valid = 1'b1; redirect_target = 10'd0;
        tick();
        chk("resume_halted", int'(halted), 0);
        redirect_valid = 1'b0;
        tick();
        chk("resume_pc", int'(out_pc), 0);

        // reset in HALTED with a full queue, together with a redirect
        out_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 10'd2;
        tick();
        redirect_valid = 1'b0;
        tick(); tick();
        chk("full_halt", int'(halted),    1);
        chk("full_head", int'(out_pc),    2);
        reset = 1'b0; redirect_valid = 1'b1; redirect_target = 10'd100;
        tick();
        chk("mrst_valid",  int'(out_valid), 0);
        chk("mrst_halted", int'(halted),    0);
        chk("mrst_fpc",    int'(fetch_pc),  0);
        reset = 1'b1; redirect_valid = 1'b0;

        // same again without the redirect
        redirect_valid = 1'b1; redirect_target = 10'd2;
        tick();
        redirect_valid = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("mrst2_valid",  int'(out_valid), 0);
        chk("mrst2_halted", int'(halted),    0);
        chk("mrst2_fpc",    int'(fetch_pc),  0);
        reset = 1'b1; out_ready = 1'b1;
        tick();
        chk("mrst2_run", int'(out_pc), 0);

        mem[3] = c_IW'(3);
        tick();
        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
